// File: rtl/serial_paralelo_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_align_pkg
// Description : Shared types and constants for the serial-to-parallel
//               aligner. Also the source of the comma used for idle fill.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_paralelo_align_pkg;

  // Link alignment state
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // K28.5 low byte, sent MSB-first
  localparam logic [7:0] COMMA_BYTE = 8'hBC;

endpackage
`default_nettype wire

// File: rtl/serial_paralelo_align_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_align_if
// Description : Serial input and byte-output bundle of the aligner.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_paralelo_align_if;
  logic       enb;
  logic       serial_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       is_comma;
  logic       active;

  // Upstream side: drives bits, consumes bytes
  modport master (
    output enb, serial_in,
    input  data_out, valid_out, is_comma, active
  );

  // Aligner side
  modport slave (
    input  enb, serial_in,
    output data_out, valid_out, is_comma, active
  );
endinterface
`default_nettype wire

// File: rtl/serial_paralelo_align_comma_detect.sv
`default_nettype none
// ============================================================================
// Module      : comma_detect
// Description : 8-bit MSB-first shift register with a look-ahead compare of
//               the value it is about to hold against the comma symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module comma_detect
  import serial_paralelo_align_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_BYTE
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       enb,
  input  wire logic       serial_in,
  output logic [7:0]      nsr,
  output logic            hit
);

  logic [7:0] sr;

  // Next shift-register value and its comma compare, used by the FSM this edge
  always_comb begin
    nsr = {sr[6:0], serial_in};
    hit = (nsr == COMMA);
  end

  // Shift one bit per enabled edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= 8'd0;
    end else if (enb) begin
      sr <= nsr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_align.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_align
// Description : Hunts for the comma in an MSB-first bitstream, locks after
//               COMMA_CNT boundary-aligned commas, then emits bytes with a
//               one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_align
  import serial_paralelo_align_pkg::*;
#(
  parameter logic [7:0] COMMA     = COMMA_BYTE,
  parameter int         COMMA_CNT = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  serial_paralelo_align_if.slave bus
);

  localparam logic [3:0] CNT_TARGET = 4'(COMMA_CNT);

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] comma_cnt, comma_cnt_n;
  logic [7:0] data_q, data_n;
  logic       valid_q, valid_n;
  logic       is_comma_q, is_comma_n;
  logic [7:0] nsr;
  logic       hit;

  comma_detect #(.COMMA(COMMA)) u_comma_detect (
    .clk       (clk),
    .reset     (reset),
    .enb       (bus.enb),
    .serial_in (bus.serial_in),
    .nsr       (nsr),
    .hit       (hit)
  );

  // Next state, counters and output values; everything holds when enb=0
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    comma_cnt_n = comma_cnt;
    data_n      = data_q;
    valid_n     = valid_q;
    is_comma_n  = is_comma_q;
    if (bus.enb) begin
      valid_n = 1'b0;
      case (state)
        HUNT: begin
          // Any bit position may start a byte while hunting
          if (hit) begin
            bit_cnt_n   = 3'd0;
            comma_cnt_n = 4'd1;
            state_n     = (CNT_TARGET == 4'd1) ? ACTIVE : ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (hit) begin
              if (comma_cnt < CNT_TARGET) begin
                comma_cnt_n = comma_cnt + 4'd1;
              end
              if (comma_cnt + 4'd1 >= CNT_TARGET) begin
                state_n = ACTIVE;
              end
            end else begin
              comma_cnt_n = 4'd0;
              state_n     = HUNT;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_n     = nsr;
            is_comma_n = hit;
            valid_n    = 1'b1;
          end
        end
        default: begin
          state_n = HUNT;
        end
      endcase
    end
  end

  // State and output registers; reset overrides any boundary update
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      bit_cnt    <= 3'd0;
      comma_cnt  <= 4'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      is_comma_q <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      comma_cnt  <= comma_cnt_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      is_comma_q <= is_comma_n;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.is_comma  = is_comma_q;
  assign bus.active    = (state == ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_paralelo_align
// Description : Bench for the serial-to-parallel aligner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_align;

  localparam int NCOMMA = 4;
  localparam int CBYTE  = 8'hBC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  serial_paralelo_align_if bus ();

  serial_paralelo_align #(.COMMA(8'hBC), .COMMA_CNT(NCOMMA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=searching, 1=counting commas, 2=locked
  int bit_hist[$];
  int m_mode = 0, m_cnt = 0, m_anchor = 0, m_n = 0;
  int m_data = 0, m_valid = 0, m_isc = 0;

  // Observations used by directed checks
  int wall = 0, rise_n = -1, vcount = 0, last_vn = -1, last_vwall = -1, last_vdata = -1;
  int prev_active = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int window();
    int w = 0;
    for (int i = bit_hist.size() - 8; i < bit_hist.size(); i++) w = w * 2 + bit_hist[i];
    return w;
  endfunction

  task automatic model(input int b, input int en, input int rst);
    int w;
    if (rst != 0) begin
      bit_hist = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_mode = 0; m_cnt = 0; m_anchor = 0; m_n = 0;
      m_data = 0; m_valid = 0; m_isc = 0;
      return;
    end
    if (en == 0) return;
    m_n++;
    bit_hist.push_back(b);
    void'(bit_hist.pop_front());
    w = window();
    m_valid = 0;
    if (m_mode == 0) begin
      if (w == CBYTE) begin
        m_anchor = m_n; m_cnt = 1;
        m_mode = (m_cnt >= NCOMMA) ? 2 : 1;
      end
    end else if ((m_n - m_anchor) % 8 == 0) begin
      if (m_mode == 1) begin
        if (w == CBYTE) begin
          m_cnt++;
          if (m_cnt >= NCOMMA) m_mode = 2;
        end else begin
          m_mode = 0; m_cnt = 0;
        end
      end else begin
        m_data = w; m_valid = 1; m_isc = (w == CBYTE) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic en, input logic rst);
    bus.serial_in = b;
    bus.enb = en;
    reset = rst;
    @(posedge clk);
    #1;
    wall++;
    model(int'(b), int'(en), int'(rst));
    check("active", int'(bus.active), (m_mode == 2) ? 1 : 0);
    check("valid_out", int'(bus.valid_out), m_valid);
    check("data_out", int'(bus.data_out), m_data);
    check("is_comma", int'(bus.is_comma), m_isc);
    if (rst) begin
      rise_n = -1; prev_active = 0;
    end else if (en) begin
      if (bus.active === 1'b1 && prev_active == 0) rise_n = m_n;
      prev_active = (bus.active === 1'b1) ? 1 : 0;
      if (bus.valid_out === 1'b1) begin
        vcount++; last_vn = m_n; last_vwall = wall; last_vdata = int'(bus.data_out);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'($urandom), 1'b1, 1'b1);
  endtask

  // Directed sequence followed by randomized locks
  initial begin
    logic [7:0] bytes6 [6];
    int gw;
    bus.enb = 1'b0;
    bus.serial_in = 1'b0;
    bit_hist = '{0, 0, 0, 0, 0, 0, 0, 0};

    // Reset values
    do_reset(3);
    check("rst_data", int'(bus.data_out), 0);
    check("rst_valid", int'(bus.valid_out), 0);
    check("rst_active", int'(bus.active), 0);

    // Aligned lock
    bytes6 = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hE6, 8'h0D};
    vcount = 0;
    for (int k = 0; k < 4; k++) send_byte(bytes6[k]);
    check("lock_rise_edge", rise_n, 32);
    send_byte(bytes6[4]);
    check("lock_v1_edge", last_vn, 40);
    check("lock_v1_data", last_vdata, 8'hE6);
    check("lock_v1_isc", int'(bus.is_comma), 0);
    send_byte(bytes6[5]);
    check("lock_v2_edge", last_vn, 48);
    check("lock_v2_data", last_vdata, 8'h0D);
    check("lock_vcount", vcount, 2);

    // Misaligned lock: three leading bits 1,0,1
    do_reset(1);
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    check("mis_rise_edge", rise_n, 35);
    send_byte(8'h5D);
    check("mis_v_edge", last_vn, 43);
    check("mis_v_data", last_vdata, 8'h5D);

    // Comma as data with a 5-cycle enable gap mid-byte
    gw = wall;
    step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    check("gap_wall_edges", last_vwall - gw, 13);
    check("gap_data", last_vdata, 8'hBC);
    check("gap_isc", int'(bus.is_comma), 1);
    check("gap_valid", int'(bus.valid_out), 1);

    // Reset in the middle of a byte while locked
    for (int k = 0; k < 4; k++) step(1'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("midrst_active", int'(bus.active), 0);
    check("midrst_valid", int'(bus.valid_out), 0);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    check("relock_not_yet", int'(bus.active), 0);
    send_byte(8'hBC);
    check("relock_active", int'(bus.active), 1);

    // Broken preamble
    do_reset(1);
    vcount = 0;
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h0D); send_byte(8'hBC);
    check("broken_active", int'(bus.active), 0);
    check("broken_vcount", vcount, 0);

    // Randomized preambles at random phase, random enable gaps, random data
    for (int it = 0; it < 6; it++) begin
      logic [7:0] v;
      do_reset(1);
      for (int k = 0; k < int'($urandom_range(0, 7)); k++) step(1'($urandom), 1'b1, 1'b0);
      for (int k = 0; k < NCOMMA + 6; k++) begin
        v = (k < NCOMMA) ? 8'hBC : 8'($urandom);
        for (int i = 7; i >= 0; i--) begin
          while ($urandom_range(0, 9) == 0) step(1'($urandom), 1'b0, 1'b0);
          step(v[i], 1'b1, 1'b0);
        end
      end
    end
    for (int k = 0; k < 300; k++) step(1'($urandom), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 199) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
